bram_port_ctrl: RTL and testbench
=================================

# bram_port_ctrl

Request/response front end for one single-port block RAM with one-cycle registered read. Accepts word accesses on a valid/ready request channel, drives the RAM's addr/data_w/en/sel pins, captures read data one cycle later and returns it on a valid/ready response channel. Supports full throughput (one access per cycle) and arbitrary response backpressure. Sits directly upstream of the RAM, between it and the core's load/store or fetch logic.

## Interface
- ADDR_W, 14, RAM word-address width
- DATA_L, 4, bytes per word; DATA_W = DATA_L*8; BYTE_W = $clog2(DATA_L)
- Reset is asynchronous, active-high; one clock domain.
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  ADDR_W+BYTE_W  byte address; low BYTE_W bits ignored
- req_wdata  in  DATA_W  write data
- req_sel  in  DATA_L  byte write enables; all-zero = read
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when valid&ready
- resp_rdata  out  DATA_W  word contents before the access
- resp_write  out  1  1 if the originating request had any sel bit set
- mem_addr  out  ADDR_W  to RAM addr
- mem_wdata  out  DATA_W  to RAM data_w
- mem_en  out  1  to RAM en
- mem_sel  out  DATA_L  to RAM sel
- mem_rdata  in  DATA_W  from RAM data_r

## Operation
- Accept = req_valid & req_ready. On accept in cycle N: mem_en=1, mem_addr=req_addr[ADDR_W+BYTE_W-1:BYTE_W], mem_wdata=req_wdata, mem_sel=req_sel, all combinational in cycle N. No accept: mem_en=0, mem_sel=0.
- In-flight flag `inflight` (1 bit) set at end of N, also latching `inflight_write` = |req_sel. In N+1, mem_rdata holds pre-write word; pushed into 2-entry response FIFO with inflight_write.
- RAM is read-before-write, so writes return the old word; callers may ignore it.
- Credit rule: pop = resp_valid & resp_ready; req_ready = (occ + inflight - pop) < 2, where occ is FIFO occupancy 0..2. Guarantees a push never hits a full FIFO.
- resp_valid = (occ != 0); resp_rdata/resp_write from FIFO head.
- Simultaneous push and pop: occ unchanged, head advances, entry order preserved. Push into empty FIFO with pop not possible same cycle (resp_valid low).
- Responses strictly in request order; no reordering, no drop.
- req_ready depends combinationally on resp_ready; mem_en depends combinationally on req_valid. No combinational path from resp_ready to resp_*.
- Reset: occ=0, inflight=0, FIFO pointers 0; in-flight access discarded, no response produced. resp_valid=0, mem_en=0, mem_sel=0 while rst high; req_ready=0 while rst high, 1 in first cycle after deassert. RAM contents not touched by reset; a write accepted before reset has been committed.

## Timing
- Latency: accept in N -> resp_valid earliest in N+2.
- Throughput: 1 access/cycle while resp_ready stays high.
- Backpressure: resp_ready low -> at most 2 further accepts (one in flight, then FIFO fills), then req_ready=0 until a pop; if a pop occurs with occ=2 and inflight=0, req_ready=1 that same cycle.
- mem_rdata is sampled only in the cycle after mem_en; the RAM holds data_r when en=0, but the controller does not rely on this.

## Structure
- Package bram_port_pkg: typedef resp_entry_t {logic write; logic [DATA_W-1:0] rdata;} (parameterized via module localparam or package function); constant RESP_DEPTH=2.
- Sub-module resp_fifo2: 2-entry register FIFO, push/pop/occ, async reset of pointers and occ only (data registers unreset).
- Top holds credit logic, inflight register, mem_* drive.

## Test plan
- Write addr 0x10, sel 4'hF, wdata 0xDEADBEEF, then read 0x10 -> write resp_write=1 with old data; read resp_rdata=0xDEADBEEF at N+2.
- Partial write sel 4'b0010, wdata 0x0000AB00 over 0x11223344 -> next read returns 0x1122AB44.
- Back-to-back reads of 8 addresses, resp_ready=1 -> req_ready never drops, 8 responses in order, first at cycle 2.
- resp_ready=0 with continuous req_valid -> exactly 2 accepts, req_ready=0, resp_valid=1 holding first data stable; release -> remaining responses in order, none lost or duplicated.
- Assert rst with inflight=1, occ=1 -> resp_valid=0 immediately; after release no stale response; earlier accepted write readable.
- Random valid/ready on both channels, 10k ops vs reference memory model -> all data and order match; mem_en never high without accept.

Source files
------------

// File: rtl/bram_port_ctrl_pkg.sv
// Shared constants and the response-entry type for the block-RAM port controller.
package bram_port_pkg;
    localparam int unsigned DATA_L     = 4;
    localparam int unsigned DATA_W     = DATA_L * 8;
    localparam int unsigned BYTE_W     = $clog2(DATA_L);
    localparam int unsigned RESP_DEPTH = 2;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] rdata;
    } resp_entry_t;
endpackage

// File: rtl/bram_port_ctrl_resp_fifo2.sv
// Two-entry register FIFO holding responses; only pointers and occupancy are reset.
module resp_fifo2
    import bram_port_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  resp_entry_t din,
    output resp_entry_t dout,
    output logic [1:0]  occ
);

    resp_entry_t mem_q [RESP_DEPTH];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  occ_q, occ_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout = mem_q[rd_ptr_q];
    assign occ  = occ_q;

endmodule

// File: rtl/bram_port_ctrl.sv
// Valid/ready front end for a single-port block RAM with one-cycle registered read.
module bram_port_ctrl
    import bram_port_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W+BYTE_W-1:0] req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [DATA_L-1:0]        req_sel,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic                     resp_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_en,
    output logic [DATA_L-1:0]        mem_sel,
    input  logic [DATA_W-1:0]        mem_rdata
);

    logic        inflight_q, inflight_d;
    logic        inflight_write_q, inflight_write_d;
    logic [1:0]  occ;
    logic [2:0]  credit;
    logic        accept;
    logic        pop;
    resp_entry_t push_entry;
    resp_entry_t head;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr[BYTE_W-1:0];
    assign resp_valid       = (occ != 2'd0);

    always_comb begin
        pop = resp_valid & resp_ready;
        // Slots already claimed: queued responses plus the read still inside the RAM.
        credit    = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
        req_ready = ~rst & (credit < 3'd2);
        accept    = req_valid & req_ready;

        mem_en    = accept;
        mem_addr  = req_addr[ADDR_W+BYTE_W-1:BYTE_W];
        mem_wdata = req_wdata;
        mem_sel   = accept ? req_sel : '0;

        inflight_d       = accept;
        inflight_write_d = accept ? (|req_sel) : inflight_write_q;

        push_entry.write = inflight_write_q;
        push_entry.rdata = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q       <= 1'b0;
            inflight_write_q <= 1'b0;
        end else begin
            inflight_q       <= inflight_d;
            inflight_write_q <= inflight_write_d;
        end
    end

    resp_fifo2 u_resp_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .pop  (pop),
        .din  (push_entry),
        .dout (head),
        .occ  (occ)
    );

    assign resp_rdata = head.rdata;
    assign resp_write = head.write;

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Self-checking bench for bram_port_ctrl: vector table, corner sequences and random traffic vs a reference memory.
module tb_bram_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_sel;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_write;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_en;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;

    int unsigned passed = 0;
    int unsigned total  = 0;

    typedef struct packed {
        logic        w;
        logic [31:0] d;
    } exp_t;
    exp_t expq[$];

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        exp_write;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[10];

    logic [31:0] ram  [16384];
    logic [31:0] refm [16384];
    bit          rnd_rr = 1'b0;

    bram_port_ctrl #(.ADDR_W(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_sel    (req_sel),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_write (resp_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_en     (mem_en),
        .mem_sel    (mem_sel),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Read-before-write RAM with registered read port.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_sel[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        return refm[a[15:2]];
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic [15:0] a, input logic [3:0] s, input logic [31:0] wd,
                         input logic ew, input logic [31:0] er, output int waits);
        bit done = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_sel   = s;
        req_wdata = wd;
        waits     = 0;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            if (req_ready) begin
                expq.push_back('{w: ew, d: er});
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) refm[a[15:2]][8*b +: 8] = wd[8*b +: 8];
                end
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            total++;
            $display("FAIL issue_timeout actual=not_accepted required=accepted addr=%0h", a);
        end
        req_valid = 1'b0;
        req_sel   = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (expq.size() == 0 && !resp_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_pending", 64'(expq.size()), 64'd0);
        chk("drain_resp_valid", 64'(resp_valid), 64'd0);
    endtask

    // Response monitor / scoreboard and RAM-pin sanity checks.
    initial begin
        forever begin
            @(negedge clk);
            chk("mem_en_vs_accept", 64'(mem_en), 64'(req_valid && req_ready));
            if (!(req_valid && req_ready)) chk("mem_sel_idle", 64'(mem_sel), 64'd0);
            if (resp_valid && resp_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    $display("FAIL resp_unexpected actual=%0h required=no_response", resp_rdata);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("resp", {31'd0, resp_write, resp_rdata}, {31'd0, e.w, e.d});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rr) resp_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #800000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          waits;
        int          idx;
        logic [31:0] held;

        vecs[0] = '{16'h0010, 4'hF, 32'hDEADBEEF, 1'b1, 32'h00000000};
        vecs[1] = '{16'h0010, 4'h0, 32'h00000000, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{16'h0020, 4'hF, 32'h11223344, 1'b1, 32'h00000000};
        vecs[3] = '{16'h0020, 4'h2, 32'h0000AB00, 1'b1, 32'h11223344};
        vecs[4] = '{16'h0020, 4'h0, 32'h00000000, 1'b0, 32'h1122AB44};
        vecs[5] = '{16'h0013, 4'h0, 32'h00000000, 1'b0, 32'hDEADBEEF};
        vecs[6] = '{16'h0010, 4'h1, 32'h000000AA, 1'b1, 32'hDEADBEEF};
        vecs[7] = '{16'h0010, 4'h0, 32'h00000000, 1'b0, 32'hDEADBEAA};
        vecs[8] = '{16'hFFFC, 4'hF, 32'h5A5A5A5A, 1'b1, 32'h00000000};
        vecs[9] = '{16'hFFFF, 4'h0, 32'h00000000, 1'b0, 32'h5A5A5A5A};

        for (int i = 0; i < 16384; i++) begin
            ram[i]  = '0;
            refm[i] = '0;
        end
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_sel    = '0;
        resp_ready = 1'b1;

        @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Table vectors back to back with the response channel always ready.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].addr, vecs[i].sel, vecs[i].wdata, vecs[i].exp_write, vecs[i].exp_rdata, waits);
            chk("table_no_stall", 64'(waits), 64'd0);
        end
        drain();

        // Latency: accept in N, nothing in N+1, response in N+2.
        issue(16'h0010, 4'h0, 32'h0, 1'b0, ref_rd(16'h0010), waits);
        chk("lat_n1_idle", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_n2_valid", 64'(resp_valid), 64'd1);
        drain();

        // Eight back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            logic [15:0] a;
            a = 16'h0200 + 16'(i * 4);
            issue(a, 4'h0, 32'h0, 1'b0, ref_rd(a), waits);
            chk("b2b_no_stall", 64'(waits), 64'd0);
        end
        drain();

        // Backpressure: seed four words, then stall the response channel.
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a;
            a = 16'h0100 + 16'(i * 4);
            issue(a, 4'hF, 32'hA0A0_0000 + 32'(i), 1'b1, ref_rd(a), waits);
        end
        drain();
        resp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1;
            req_sel   = 4'h0;
            req_addr  = 16'h0100 + 16'(idx * 4);
            @(negedge clk);
            if (req_ready) begin
                expq.push_back('{w: 1'b0, d: ref_rd(req_addr)});
                idx++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accept_count", 64'(idx), 64'd2);
        req_addr = 16'h0100 + 16'(idx * 4);
        @(negedge clk);
        chk("bp_req_ready_low", 64'(req_ready), 64'd0);
        chk("bp_resp_valid", 64'(resp_valid), 64'd1);
        chk("bp_head_data", 64'(resp_rdata), 64'(expq[0].d));
        held = resp_rdata;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_head_stable", 64'(resp_rdata), 64'(held));
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(req_ready), 64'd1);
        if (req_ready) begin
            expq.push_back('{w: 1'b0, d: ref_rd(req_addr)});
            idx++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        while (idx < 4) begin
            logic [15:0] a;
            a = 16'h0100 + 16'(idx * 4);
            issue(a, 4'h0, 32'h0, 1'b0, ref_rd(a), waits);
            idx++;
        end
        drain();

        // Reset with one response queued and one read in flight.
        resp_ready = 1'b0;
        issue(16'h0040, 4'hF, 32'hCAFEF00D, 1'b1, ref_rd(16'h0040), waits);
        issue(16'h0044, 4'h0, 32'h0, 1'b0, ref_rd(16'h0044), waits);
        rst = 1'b1;
        #1;
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        expq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_after", 64'(req_ready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_no_stale", 64'(resp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        issue(16'h0040, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, waits);
        drain();

        // Random traffic on both channels against the reference memory.
        rnd_rr = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            logic [15:0] a;
            logic [3:0]  s;
            logic [31:0] wd;
            a  = {10'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            s  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            issue(a, s, wd, |s, ref_rd(a), waits);
        end
        rnd_rr = 1'b0;
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
